// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver with 16x oversampling, start-bit validation and stop-bit framing checks.
// Received bytes are offered on a valid/ready output; frame_err and overrun are one-clock pulses.
module uart_rx_os16 #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_r,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy,
  output logic [2:0] dbg_state
);

  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_div_cnt;
  state_t        r_state;
  logic [3:0]    r_sc;
  logic [2:0]    r_bi;
  logic [7:0]    r_shreg;
  logic [7:0]    r_rx_data;
  logic          r_rx_valid;
  logic          r_frame_err;
  logic          r_overrun;
  logic          r_busy;

  logic w_rx_s;
  logic w_tick;
  logic w_stop_sample;
  logic w_deliver;
  logic w_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= data_r;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
    end else if (r_div_cnt == DIV_LAST) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + CW'(1);
    end
  end

  assign w_tick = (r_div_cnt == DIV_LAST);

  // START checks the line 8 ticks in (about mid start bit); DATA/STOP then sample every 16th tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sc    <= 4'd0;
      r_bi    <= 3'd0;
      r_shreg <= 8'h00;
      r_busy  <= 1'b0;
    end else if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_state <= S_START;
            r_sc    <= 4'd0;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (r_sc == 4'd7) begin
            r_sc <= 4'd0;
            if (!w_rx_s) begin
              r_state <= S_DATA;
              r_bi    <= 3'd0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_sc <= r_sc + 4'd1;
          end
        end
        S_DATA: begin
          if (r_sc == 4'd15) begin
            r_sc          <= 4'd0;
            r_shreg[r_bi] <= w_rx_s;
            if (r_bi == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bi <= r_bi + 3'd1;
            end
          end else begin
            r_sc <= r_sc + 4'd1;
          end
        end
        S_STOP: begin
          if (r_sc == 4'd15) begin
            r_sc <= 4'd0;
            if (w_rx_s) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_BREAK;
            end
          end else begin
            r_sc <= r_sc + 4'd1;
          end
        end
        S_BREAK: begin
          if (w_rx_s) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign w_stop_sample = w_tick && (r_state == S_STOP) && (r_sc == 4'd15);
  assign w_deliver     = w_stop_sample && w_rx_s;
  assign w_accept      = r_rx_valid && rx_ready;

  // Handshake: rx_data is held stable while rx_valid=1; a transfer happens on any clk edge
  // with rx_valid&rx_ready. A byte arriving while the slot is full and not accepted is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_stop_sample && !w_rx_s;
      r_overrun   <= 1'b0;
      if (w_deliver) begin
        if (!r_rx_valid || w_accept) begin
          r_rx_data  <= r_shreg;
          r_rx_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_accept) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16: serial frames are built from bytes, expected bytes queued, and a
// negedge monitor checks every accepted byte and counts error pulses.
module tb_uart_rx_os16;

  localparam int CLK_HZ = 1_536_000;
  localparam int BAUD   = 9600;
  localparam int BITCLK = 160;

  logic       clk;
  logic       rst_n;
  logic       data_r;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  logic [2:0] dbg_state;

  uart_rx_os16 #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_r    (data_r),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset-relative cycle count
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc;
  always @(posedge clk) begin
    if (!rst_n) cyc = 0;
    else        cyc = cyc + 1;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard state
  logic [7:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int exp_ferr = 0;
  int exp_ovr  = 0;

  int ferr_cnt  = 0;
  int ovr_cnt   = 0;
  int vrise     = 0;
  int vhigh     = 0;
  int vrise_cyc = 0;
  int busy_run  = 0;
  int busy_max  = 0;
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  logic [7:0] exp_b;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      busy_run   = 0;
    end else begin
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got=%0h want=none", rx_data);
        end else begin
          exp_b = exp_q.pop_front();
          check("rx_data", int'(rx_data), int'(exp_b));
        end
      end
      if (prev_valid && !prev_ready) begin
        check("valid_hold", int'(rx_valid), 1);
        check("data_hold", int'(rx_data), int'(prev_data));
      end
      if (frame_err && overrun) check("err_ovr_exclusive", 1, 0);
      if (rx_valid && !prev_valid) begin
        vrise++;
        vrise_cyc = int'(cyc);
      end
      if (rx_valid)  vhigh++;
      if (frame_err) ferr_cnt++;
      if (overrun)   ovr_cnt++;
      busy_run = busy ? busy_run + 1 : 0;
      if (busy_run > busy_max) busy_max = busy_run;
      prev_valid = rx_valid;
      prev_ready = rx_ready;
      prev_data  = rx_data;
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int bit_clk);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      data_r = frame[i];
      step(bit_clk);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"},   int'(rx_data),   0);
    check({tag, "_rx_valid"},  int'(rx_valid),  0);
    check({tag, "_frame_err"}, int'(frame_err), 0);
    check({tag, "_overrun"},   int'(overrun),   0);
    check({tag, "_busy"},      int'(busy),      0);
    check({tag, "_state"},     int'(dbg_state), 0);
  endtask

  int p0;
  int lat;
  int v0;
  int h0;
  logic [7:0] rb;
  logic       rstop;
  int         rbc;

  initial begin
    rst_n    = 1'b0;
    data_r   = 1'b1;
    rx_ready = 1'b0;
    step(5);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step(20);

    // single byte, consumer always ready
    rx_ready = 1'b1;
    v0 = vrise;
    h0 = vhigh;
    exp_q.push_back(8'h58);
    p0 = int'(cyc);
    send_byte(8'h58, 1'b1, BITCLK);
    step(50);
    lat = vrise_cyc - p0;
    check("single_valid_rise", vrise - v0, 1);
    check("single_valid_width", vhigh - h0, 1);
    check("single_latency", int'(lat >= 1515 && lat <= 1535), 1);
    check("single_ferr", ferr_cnt, exp_ferr);
    check("single_ovr", ovr_cnt, exp_ovr);

    // glitch on idle line
    v0 = vrise;
    busy_max = 0;
    data_r = 1'b0;
    step(60);
    data_r = 1'b1;
    step(200);
    check("glitch_state_idle", int'(dbg_state), 0);
    check("glitch_no_valid", vrise - v0, 0);
    check("glitch_busy_short", int'(busy_max > 0 && busy_max < 100), 1);

    // back-to-back with backpressure
    rx_ready = 1'b0;
    v0 = vrise;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1, BITCLK);
    send_byte(8'h3C, 1'b1, BITCLK);
    exp_ovr++;
    step(100);
    check("bp_valid", int'(rx_valid), 1);
    check("bp_data", int'(rx_data), 8'hA5);
    check("bp_ovr", ovr_cnt, exp_ovr);
    check("bp_one_rise", vrise - v0, 1);
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    check("bp_after_accept", int'(rx_valid), 0);
    step(20);

    // accept coincides with delivery of the next byte
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b1, BITCLK);
    step(50);
    check("sim_hold_valid", int'(rx_valid), 1);
    while ((cyc % 10) != 7) step(1);
    p0 = int'(cyc);
    exp_q.push_back(8'h22);
    fork
      send_byte(8'h22, 1'b1, BITCLK);
      begin
        step(1522);
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
        check("sim_valid", int'(rx_valid), 1);
        check("sim_data", int'(rx_data), 8'h22);
        check("sim_no_overrun", int'(overrun), 0);
      end
    join
    step(20);
    check("sim_ovr_count", ovr_cnt, exp_ovr);
    rx_ready = 1'b1;
    step(2);

    // framing error followed by a held-low break
    v0 = vrise;
    send_byte(8'h00, 1'b0, BITCLK);
    exp_ferr++;
    step(2000);
    check("break_busy", int'(busy), 1);
    check("break_ferr_once", ferr_cnt, exp_ferr);
    check("break_no_valid", vrise - v0, 0);
    data_r = 1'b1;
    step(40);
    check("break_busy_released", int'(busy), 0);
    exp_q.push_back(8'hFF);
    send_byte(8'hFF, 1'b1, BITCLK);
    step(100);
    check("after_break_rise", vrise - v0, 1);

    // randomized frames with baud mismatch and occasional bad stop bits
    for (int n = 0; n < 8; n++) begin
      rb    = 8'($urandom_range(0, 255));
      rstop = ($urandom_range(0, 4) != 0);
      rbc   = int'($urandom_range(156, 164));
      if (rstop) exp_q.push_back(rb);
      else       exp_ferr++;
      send_byte(rb, rstop, rbc);
      data_r = 1'b1;
      step(int'($urandom_range(40, 300)));
    end
    check("rand_ferr", ferr_cnt, exp_ferr);
    check("rand_ovr", ovr_cnt, exp_ovr);
    check("rand_drained", exp_q.size(), 0);

    // reset in the middle of a frame with a byte still pending
    rx_ready = 1'b0;
    send_byte(8'h77, 1'b1, BITCLK);
    step(20);
    check("pre_reset_valid", int'(rx_valid), 1);
    fork
      send_byte(8'h5A, 1'b1, BITCLK);
      begin
        step(720);
        rst_n = 1'b0;
        step(3);
        check_reset_outputs("midreset");
      end
    join
    step(20);
    check_reset_outputs("held_reset");
    rst_n = 1'b1;
    step(20);
    v0 = vrise;
    rx_ready = 1'b1;
    exp_q.push_back(8'hC3);
    send_byte(8'hC3, 1'b1, BITCLK);
    step(100);
    check("post_reset_one_byte", vrise - v0, 1);

    check("final_drained", exp_q.size(), 0);
    check("final_ferr", ferr_cnt, exp_ferr);
    check("final_ovr", ovr_cnt, exp_ovr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
